// File: rtl/timer_down.sv
// timer_down: M:SS countdown timer (minutes 0-9, tens of seconds 0-5, seconds 0-9).
// A clamped BCD preset is loaded, then decremented once per CLK_DIV clocks while running.
// Reaching 0:00 pulses DONE for one cycle.
// Optional feature macro: TIMER_ALARM_EN. When it is defined, an ALARM state holds ALARM
// high for ALARM_LEN ticks after 0:00, or until START or LOAD ends it.
// When it is undefined, the timer returns straight to IDLE and ALARM stays 0.
module timer_down #(
    parameter int unsigned CLK_DIV   = 25000000,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       LOAD,
    input  logic [3:0] LOAD_M,
    input  logic [3:0] LOAD_10,
    input  logic [3:0] LOAD_1,
    input  logic       START,
    input  logic       PAUSE,
    output logic [3:0] COUNT_M,
    output logic [3:0] COUNT_10,
    output logic [3:0] COUNT_1,
    output logic       RUNNING,
    output logic       DONE,
    output logic       ALARM
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Elaboration-time guards on the parameter ranges
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("timer_down: CLK_DIV must be at least 2");
    end
    if (ALARM_LEN < 1) begin : g_bad_alarm_len
        $error("timer_down: ALARM_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_ALARM  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [3:0]      m_d;
    logic [3:0]      t_d;
    logic [3:0]      o_d;
    logic [3:0]      m_dec;
    logic [3:0]      t_dec;
    logic [3:0]      o_dec;
    logic            done_d;
    logic            tick;
    logic            is_zero;
    logic            at_one;

`ifdef TIMER_ALARM_EN
    localparam int unsigned AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    logic [AW-1:0]   alm_q;
    logic [AW-1:0]   alm_d;
`endif

    // Count status and prescaler terminal value
    assign tick    = (presc_q == PW'(CLK_DIV - 1));
    assign is_zero = (COUNT_M == 4'd0) && (COUNT_10 == 4'd0) && (COUNT_1 == 4'd0);
    assign at_one  = (COUNT_M == 4'd0) && (COUNT_10 == 4'd0) && (COUNT_1 == 4'd1);

    // One-second decrement of the BCD digits with borrow from seconds into tens into minutes
    always_comb begin
        m_dec = COUNT_M;
        t_dec = COUNT_10;
        o_dec = COUNT_1;
        if (COUNT_1 != 4'd0) begin
            o_dec = COUNT_1 - 4'd1;
        end else begin
            o_dec = 4'd9;
            if (COUNT_10 != 4'd0) begin
                t_dec = COUNT_10 - 4'd1;
            end else begin
                t_dec = 4'd5;
                m_dec = COUNT_M - 4'd1;
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath updates; LOAD beats START, START beats PAUSE
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        m_d     = COUNT_M;
        t_d     = COUNT_10;
        o_d     = COUNT_1;
        done_d  = 1'b0;
`ifdef TIMER_ALARM_EN
        alm_d   = alm_q;
`endif
        if (LOAD) begin
            m_d     = (LOAD_M  > 4'd9) ? 4'd9 : LOAD_M;
            t_d     = (LOAD_10 > 4'd5) ? 4'd5 : LOAD_10;
            o_d     = (LOAD_1  > 4'd9) ? 4'd9 : LOAD_1;
            presc_d = '0;
            state_d = S_IDLE;
`ifdef TIMER_ALARM_EN
            alm_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !is_zero) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_PAUSED: begin
                    // Prescaler is kept so the sub-second phase survives the pause
                    if (START && !is_zero) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (is_zero) begin
                            state_d = S_IDLE;
                        end else begin
                            m_d = m_dec;
                            t_d = t_dec;
                            o_d = o_dec;
                            if (at_one) begin
                                done_d = 1'b1;
`ifdef TIMER_ALARM_EN
                                state_d = S_ALARM;
                                alm_d   = '0;
`else
                                state_d = S_IDLE;
`endif
                            end else if (PAUSE) begin
                                state_d = S_PAUSED;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        if (PAUSE) begin
                            state_d = S_PAUSED;
                        end
                    end
                end
`ifdef TIMER_ALARM_EN
                S_ALARM: begin
                    if (START) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                        alm_d   = '0;
                    end else if (tick) begin
                        presc_d = '0;
                        if (alm_q == AW'(ALARM_LEN - 1)) begin
                            state_d = S_IDLE;
                            alm_d   = '0;
                        end else begin
                            alm_d = alm_q + AW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Registered digits, prescaler and status outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q  <= '0;
            COUNT_M  <= 4'd0;
            COUNT_10 <= 4'd0;
            COUNT_1  <= 4'd0;
            RUNNING  <= 1'b0;
            DONE     <= 1'b0;
            ALARM    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            COUNT_M  <= m_d;
            COUNT_10 <= t_d;
            COUNT_1  <= o_d;
            RUNNING  <= (state_d == S_RUN);
            DONE     <= done_d;
`ifdef TIMER_ALARM_EN
            ALARM    <= (state_d == S_ALARM);
`else
            ALARM    <= 1'b0;
`endif
        end
    end

`ifdef TIMER_ALARM_EN
    // Alarm duration counter, counted in prescaler ticks
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            alm_q <= '0;
        end else begin
            alm_q <= alm_d;
        end
    end
`endif

endmodule

// File: tb/tb_timer_down.sv
// tb_timer_down: directed stimulus for timer_down with CLK_DIV=4, ALARM_LEN=2.
// A seconds-based reference model is checked against the design every cycle,
// alongside hand-computed literal expectations.
module tb_timer_down;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned ALARM_LEN = 2;
`ifdef TIMER_ALARM_EN
    localparam bit AE = 1'b1;
`else
    localparam bit AE = 1'b0;
`endif

    localparam int MD_IDLE   = 0;
    localparam int MD_RUN    = 1;
    localparam int MD_PAUSED = 2;
    localparam int MD_ALARM  = 3;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] lm;
    logic [3:0] l10;
    logic [3:0] l1;
    logic       start;
    logic       pause;
    logic [3:0] cm;
    logic [3:0] c10;
    logic [3:0] c1;
    logic       running;
    logic       done;
    logic       alarm;
    logic [14:0] dut_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model state: total seconds, phase within the second, mode
    int m_secs       = 0;
    int m_phase      = 0;
    int m_mode       = MD_IDLE;
    int m_done       = 0;
    int m_alarm_left = 0;

    timer_down #(.CLK_DIV(CLK_DIV), .ALARM_LEN(ALARM_LEN)) dut (
        .CLK(clk), .RESET_N(rst_n), .LOAD(load), .LOAD_M(lm), .LOAD_10(l10), .LOAD_1(l1),
        .START(start), .PAUSE(pause), .COUNT_M(cm), .COUNT_10(c10), .COUNT_1(c1),
        .RUNNING(running), .DONE(done), .ALARM(alarm)
    );

    assign dut_vec = {cm, c10, c1, running, done, alarm};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clampv(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    function automatic logic [14:0] pk(input int m, input int t, input int o,
                                       input bit r, input bit d, input bit a);
        return {4'(m), 4'(t), 4'(o), r, d, a};
    endfunction

    function automatic logic [14:0] model_vec();
        return pk(m_secs / 60, (m_secs % 60) / 10, m_secs % 10,
                  m_mode == MD_RUN, m_done != 0, m_mode == MD_ALARM);
    endfunction

    // Reference model: advances on each sampled edge from the specification's rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_secs = 0; m_phase = 0; m_mode = MD_IDLE; m_done = 0; m_alarm_left = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_secs  = clampv(lm, 9) * 60 + clampv(l10, 5) * 10 + clampv(l1, 9);
                m_phase = 0;
                m_mode  = MD_IDLE;
            end else if (m_mode == MD_IDLE) begin
                if (start && m_secs != 0) begin
                    m_mode  = MD_RUN;
                    m_phase = 0;
                end
            end else if (m_mode == MD_PAUSED) begin
                if (start && m_secs != 0) m_mode = MD_RUN;
            end else if (m_mode == MD_RUN) begin
                m_phase = m_phase + 1;
                if (m_phase == CLK_DIV) begin
                    m_phase = 0;
                    m_secs  = m_secs - 1;
                    if (m_secs == 0) begin
                        m_done = 1;
                        if (AE) begin
                            m_mode       = MD_ALARM;
                            m_alarm_left = ALARM_LEN * CLK_DIV;
                        end else begin
                            m_mode = MD_IDLE;
                        end
                    end else if (pause) begin
                        m_mode = MD_PAUSED;
                    end
                end else if (pause) begin
                    m_mode = MD_PAUSED;
                end
            end else begin
                if (start) begin
                    m_mode = MD_IDLE;
                end else begin
                    m_alarm_left = m_alarm_left - 1;
                    if (m_alarm_left == 0) m_mode = MD_IDLE;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [14:0] req);
        checks++;
        if (dut_vec !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (m,t,o,run,done,alarm)", name, dut_vec, req);
        end
    endtask

    // Advance n cycles, comparing the design with the model at each falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (dut_vec !== model_vec()) begin
                    failures++;
                    $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, dut_vec, model_vec());
                end
            end
        end
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; lm = m; l10 = t; l1 = o;
        step(1);
        load = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; lm = 4'd0; l10 = 4'd0; l1 = 4'd0;
        start = 1'b0; pause = 1'b0;
        step(2);
        chk("reset_state", pk(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(1);

        // 1:00 counts down to 0:59 and 0:58
        do_load(4'd1, 4'd0, 4'd0);
        chk("load_1_00", pk(1, 0, 0, 0, 0, 0));
        start_pulse();
        chk("s1_running", pk(1, 0, 0, 1, 0, 0));
        step(3);
        chk("s1_hold", pk(1, 0, 0, 1, 0, 0));
        step(1);
        chk("s1_0_59", pk(0, 5, 9, 1, 0, 0));
        step(4);
        chk("s1_0_58", pk(0, 5, 8, 1, 0, 0));
        do_load(4'd0, 4'd0, 4'd2);
        chk("load_in_run", pk(0, 0, 2, 0, 0, 0));

        // 0:02 reaches 0:00 with a DONE pulse and optional alarm
        start_pulse();
        step(4);
        chk("s2_0_01", pk(0, 0, 1, 1, 0, 0));
        step(3);
        chk("s2_pre_done", pk(0, 0, 1, 1, 0, 0));
        step(1);
        chk("s2_done", pk(0, 0, 0, 0, 1, AE));
        step(1);
        chk("s2_done_gone", pk(0, 0, 0, 0, 0, AE));
        step(6);
        chk("s2_alarm_last", pk(0, 0, 0, 0, 0, AE));
        step(1);
        chk("s2_idle", pk(0, 0, 0, 0, 0, 0));
        start_pulse();
        chk("zero_start", pk(0, 0, 0, 0, 0, 0));
        step(5);

        // Pause keeps the sub-second phase
        do_load(4'd0, 4'd1, 4'd0);
        start_pulse();
        step(1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("paused", pk(0, 1, 0, 0, 0, 0));
        step(20);
        chk("pause_hold", pk(0, 1, 0, 0, 0, 0));
        start_pulse();
        chk("resume", pk(0, 1, 0, 1, 0, 0));
        step(1);
        chk("resume_p1", pk(0, 1, 0, 1, 0, 0));
        step(1);
        chk("resume_0_09", pk(0, 0, 9, 1, 0, 0));

        // Pause in the tick cycle: decrement first, then pause
        do_load(4'd0, 4'd0, 4'd3);
        start_pulse();
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("pause_on_tick", pk(0, 0, 2, 0, 0, 0));
        step(3);
        start_pulse();
        step(3);
        chk("resume_full_hold", pk(0, 0, 2, 1, 0, 0));
        step(1);
        chk("resume_full_0_01", pk(0, 0, 1, 1, 0, 0));

        // Clamping of out-of-range preset digits
        do_load(4'd12, 4'd7, 4'd15);
        chk("clamp", pk(9, 5, 9, 0, 0, 0));

        // Asynchronous reset mid-count
        do_load(4'd2, 4'd0, 4'd0);
        start_pulse();
        step(4);
        chk("s5_1_59", pk(1, 5, 9, 1, 0, 0));
        step(2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", pk(0, 0, 0, 0, 0, 0));
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_reset", pk(0, 0, 0, 0, 0, 0));

        // START during the alarm acknowledges it
        do_load(4'd0, 4'd0, 4'd1);
        start_pulse();
        step(4);
        chk("s6_terminal", pk(0, 0, 0, 0, 1, AE));
        step(1);
        start_pulse();
        chk("s6_ack", pk(0, 0, 0, 0, 0, 0));
        step(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
